// File: rtl/sysx_slave.sv
`default_nettype none
// ============================================================================
//  Module   : sysx_slave
//  Purpose  : sysX peripheral-bus responder. Oversamples the master's bus
//             clock, select and MOSI lanes in the local clock domain and
//             decodes a command byte followed by four data bytes. Each
//             transaction becomes one access on a 16 x 32-bit local register
//             strobe interface. Register 15 is an internal interrupt status
//             register.
//  Ports    : iClock/iReset          local clock, async active-high reset
//             iBusClock/iBusSelect/  master bus inputs (asynchronous)
//             iBusMOSI
//             oBusMISO/oBusInterrupt slave bus outputs (MISO is 0 unless this
//                                    slave is driving read data)
//             oRegAddr/oRegWrData/   local register strobe interface
//             oRegWrite/oRegRead/
//             iRegRdData
//             iIrqRequest            local interrupt request (rising edge)
//  Revision : 1.0 - initial release
// ============================================================================
module sysx_slave #(
    parameter logic [1:0] DEVICE_ID = 2'd1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [0:1]  iBusSelect,
    input  logic [0:7]  iBusMOSI,
    output logic [0:7]  oBusMISO,
    output logic        oBusInterrupt,
    output logic [0:3]  oRegAddr,
    output logic [0:31] oRegWrData,
    output logic        oRegWrite,
    output logic        oRegRead,
    input  logic [0:31] iRegRdData,
    input  logic        iIrqRequest
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [0:3] STATUS_IDX = 4'hF;

    // Synchronizers
    logic        bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic [0:1]  sel_s1_q, sel_s2_q;
    logic [0:7]  mosi_s1_q, mosi_s2_q;
    logic        irq_s1_q, irq_s2_q, irq_s3_q;

    // Control / datapath
    logic [1:0]  settle_q;
    logic        armed_q;
    logic        pending_q;
    state_t      state_q;
    logic [0:3]  addr_q;
    logic [0:31] wr_data_q;
    logic        wr_stb_q;
    logic        rd_stb_q;
    logic        rd_d1_q, rd_d2_q;
    logic [1:0]  byte_cnt_q;
    logic [0:31] shift_q;
    logic [0:7]  miso_q;

    logic        bclk_rise, bclk_fall, irq_rise, selected, status_clr;

    assign bclk_rise = bclk_s2_q & ~bclk_s3_q;
    assign bclk_fall = ~bclk_s2_q & bclk_s3_q;
    assign irq_rise  = irq_s2_q & ~irq_s3_q;
    assign selected  = (sel_s2_q == DEVICE_ID);

    // Status read capture point: the same cycle the FSM loads the shift
    // register with {pending, 0}.
    assign status_clr = (state_q == ST_RDATA) && selected && rd_d2_q &&
                        (addr_q == STATUS_IDX);

    assign oBusMISO      = miso_q;
    assign oBusInterrupt = pending_q;
    assign oRegAddr      = addr_q;
    assign oRegWrData    = wr_data_q;
    assign oRegWrite     = wr_stb_q;
    assign oRegRead      = rd_stb_q;

    // Input synchronization, post-reset arming and interrupt pending flag
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            sel_s1_q  <= 2'b00;
            sel_s2_q  <= 2'b00;
            mosi_s1_q <= 8'h00;
            mosi_s2_q <= 8'h00;
            irq_s1_q  <= 1'b0;
            irq_s2_q  <= 1'b0;
            irq_s3_q  <= 1'b0;
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            bclk_s1_q <= iBusClock;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            sel_s1_q  <= iBusSelect;
            sel_s2_q  <= sel_s1_q;
            mosi_s1_q <= iBusMOSI;
            mosi_s2_q <= mosi_s1_q;
            irq_s1_q  <= iIrqRequest;
            irq_s2_q  <= irq_s1_q;
            irq_s3_q  <= irq_s2_q;

            // The cleared synchronizers read as "deselected" right after
            // reset, so a genuine deselect is only trusted once the select
            // pipeline has refilled. Until then a select held across reset
            // is ignored.
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end else if (!selected) begin
                armed_q <= 1'b1;
            end

            // A new request wins over a coincident status-read clear.
            if (irq_rise) begin
                pending_q <= 1'b1;
            end else if (status_clr) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Transaction FSM with registered outputs
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 4'h0;
            wr_data_q  <= 32'h0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            rd_d1_q    <= 1'b0;
            rd_d2_q    <= 1'b0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'h0;
            miso_q     <= 8'h00;
        end else begin
            wr_stb_q <= 1'b0;
            rd_stb_q <= 1'b0;
            rd_d1_q  <= 1'b0;
            rd_d2_q  <= rd_d1_q;

            if (!selected) begin
                // Deselect aborts from any state; no pending strobe survives.
                state_q <= ST_IDLE;
                miso_q  <= 8'h00;
                rd_d2_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (armed_q) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (bclk_rise) begin
                            addr_q     <= mosi_s2_q[4:7];
                            byte_cnt_q <= 2'd0;
                            if (mosi_s2_q[0]) begin
                                state_q <= ST_WDATA;
                            end else begin
                                state_q  <= ST_RDATA;
                                rd_stb_q <= (mosi_s2_q[4:7] != STATUS_IDX);
                                rd_d1_q  <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (bclk_rise) begin
                            shift_q    <= {shift_q[8:31], mosi_s2_q};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                state_q <= ST_DONE;
                                if (addr_q != STATUS_IDX) begin
                                    wr_data_q <= {shift_q[8:31], mosi_s2_q};
                                    wr_stb_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Local read data is valid the cycle after the strobe;
                        // rd_d2_q marks that cycle.
                        if (rd_d2_q) begin
                            shift_q <= (addr_q == STATUS_IDX) ?
                                       {pending_q, 31'b0} : iRegRdData;
                        end else if (bclk_fall) begin
                            miso_q  <= shift_q[0:7];
                            shift_q <= {shift_q[8:31], 8'h00};
                        end
                        if (bclk_rise) begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                state_q <= ST_DONE;
                                miso_q  <= 8'h00;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Hold until deselect.
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
